// File: rtl/max_pool_2x2_pkg.sv
// Shared defaults and the signed max helper for the 2x2 max-pool block.
// The helper works at MAX_DW bits; callers sign-extend narrower pixels into it.
package max_pool_2x2_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_IMG_WIDTH  = 28;
  localparam int DEF_IMG_HEIGHT = 28;
  localparam int MAX_DW         = 64;

  function automatic logic signed [MAX_DW-1:0] smax(
    input logic signed [MAX_DW-1:0] a,
    input logic signed [MAX_DW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/max_pool_2x2_line_buf.sv
// Half-row line buffer holding the per-column-pair maxima of the even row.
// Single clock, one write port, combinational read, contents never reset.
module pool_line_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 14,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2/stride-2 signed max pooling over raster-order pixels; one result per window,
// one cycle after its bottom-right pixel. Optional frame_done output under MAX_POOL_FRAME_DONE_EN.
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef MAX_POOL_FRAME_DONE_EN
  ,
  output logic                  frame_done
`endif
);

  localparam int CW       = $clog2(IMG_WIDTH);
  localparam int RW       = $clog2(IMG_HEIGHT);
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  function automatic logic [DATA_WIDTH-1:0] max_dw(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic signed [MAX_DW-1:0] r;
    r = smax(MAX_DW'($signed(a)), MAX_DW'($signed(b)));
    return r[DATA_WIDTH-1:0];
  endfunction

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic                  in_fire, out_fire, res_load;
  logic                  col_last, row_last;
  logic                  lb_we;
  logic [AW-1:0]         lb_addr;
  logic [DATA_WIDTH-1:0] lb_wdata, lb_rdata;

  assign in_ready  = !out_valid_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign res_load  = in_fire && row_q[0] && col_q[0];
  assign col_last  = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last  = (row_q == RW'(IMG_HEIGHT - 1));
  assign lb_addr   = AW'(col_q >> 1);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  pool_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (LB_DEPTH),
    .AW        (AW)
  ) u_line_buf (
    .clk    (clk),
    .we_i   (lb_we),
    .waddr_i(lb_addr),
    .wdata_i(lb_wdata),
    .raddr_i(lb_addr),
    .rdata_o(lb_rdata)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    h_d         = h_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    lb_we       = 1'b0;
    lb_wdata    = max_dw(h_q, in_data);

    if (out_fire) out_valid_d = 1'b0;

    if (in_fire) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      // {odd row, odd col} selects the window phase of this pixel.
      case ({row_q[0], col_q[0]})
        2'b00:   h_d = in_data;
        2'b01:   lb_we = 1'b1;
        2'b10:   h_d = max_dw(lb_rdata, in_data);
        default: begin
          out_data_d  = max_dw(h_q, in_data);
          out_valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      h_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      h_q         <= h_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MAX_POOL_FRAME_DONE_EN
  logic last_q;

  // Tags the held result as the frame's final window until it is replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
    end else if (res_load) begin
      last_q <= row_last && col_last;
    end
  end

  assign frame_done = out_fire && last_q;
`else
  logic unused_res_load;
  assign unused_res_load = res_load;
`endif

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed and randomized-gap bench for max_pool_2x2 on a 4x4 image of 32-bit signed pixels.
module tb_max_pool_2x2;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int OUTS = (W / 2) * (H / 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
`ifdef MAX_POOL_FRAME_DONE_EN
  logic        frame_done;
`endif

  max_pool_2x2 #(
    .DATA_WIDTH(32),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef MAX_POOL_FRAME_DONE_EN
    ,
    .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          out_cnt = 0;
  bit          rand_out = 1'b0;
  logic [31:0] obs_q[$];
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] smax2(input logic [31:0] a, input logic [31:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Reference: keep the whole frame and pool each window once its last pixel lands.
  logic [31:0] fb [H][W];
  int          mr = 0, mc = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_val = '0;

  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (rst) begin
      mr = 0; mc = 0; pend = 1'b0; out_cnt = 0;
    end else begin
      check("rdy_eq", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (pend) begin
        check("lat_vld", {31'd0, out_valid}, 32'd1);
        check("lat_dat", out_data, pend_val);
        pend = 1'b0;
      end
`ifdef MAX_POOL_FRAME_DONE_EN
      check("fdone", {31'd0, frame_done},
            {31'd0, (out_valid && out_ready && (out_cnt % OUTS == OUTS - 1))});
`endif
      if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        fb[mr][mc] = in_data;
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
          e = smax2(smax2(fb[mr-1][mc-1], fb[mr-1][mc]), smax2(fb[mr][mc-1], fb[mr][mc]));
          model_q.push_back(e);
          pend = 1'b1;
          pend_val = e;
        end
        if (mc == W - 1) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
          mc++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_out) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input bit gaps);
    bit acc;
    int t;
    in_valid = 1'b0;
    if (gaps) while ($urandom_range(0, 1) == 1) step();
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) break;
      t++;
      if (t > 300) begin
        check("push_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int t = 0;
    while (obs_q.size() < n && t < 400) begin
      step();
      t++;
    end
    repeat (4) step();
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_cnt"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
  endtask

  initial begin
    int          start;
    int          a0;
    logic [31:0] neg100;
    neg100 = 32'hFFFF_FF9C;

    repeat (2) @(negedge clk);
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_dat", out_data, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();

    // Plain frame: full rate, one output per window.
    obs_q = {};
    start = cyc;
    for (int i = 0; i < 16; i++) push(32'(i), 1'b0);
    check("rate_cycles", 32'(cyc - start), 32'd16);
    wait_outs(4);
    exp_q = {32'd5, 32'd7, 32'd13, 32'd15};
    check_outs("frame0");

    // Signed comparison.
    obs_q = {};
    push(32'hFFFF_FFFD, 1'b0); push(32'hFFFF_FFFF, 1'b0); push(neg100, 1'b0); push(neg100, 1'b0);
    push(32'hFFFF_FFF8, 1'b0); push(32'hFFFF_FFFE, 1'b0); push(neg100, 1'b0); push(neg100, 1'b0);
    for (int i = 0; i < 8; i++) push(neg100, 1'b0);
    wait_outs(4);
    exp_q = {32'hFFFF_FFFF, neg100, neg100, neg100};
    check_outs("signed");

    // Back-to-back frames.
    obs_q = {};
    for (int i = 0; i < 32; i++) push(32'(i), 1'b0);
    wait_outs(8);
    exp_q = {32'd5, 32'd7, 32'd13, 32'd15, 32'd21, 32'd23, 32'd29, 32'd31};
    check_outs("b2b");

    // Backpressure on the first output.
    obs_q = {};
    acc_cnt = 0;
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 16; i++) push(32'(i), 1'b0);
      begin
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        a0 = acc_cnt;
        check("bp_acc", 32'(a0), 32'd6);
        repeat (5) begin
          @(negedge clk);
          check("bp_dat", out_data, 32'd5);
          check("bp_rdy", {31'd0, in_ready}, 32'd0);
          check("bp_hold", 32'(acc_cnt), 32'(a0));
        end
        step();
        out_ready = 1'b1;
      end
    join
    wait_outs(4);
    exp_q = {32'd5, 32'd7, 32'd13, 32'd15};
    check_outs("bp");

    // Reset mid-frame: a stalled partial result must be discarded.
    obs_q = {};
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(32'(i + 100), 1'b0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    check("mid_rst_dat", out_data, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("mid_rst_none", obs_q.size(), 32'd0);
    for (int i = 0; i < 16; i++) push(32'(i), 1'b0);
    wait_outs(4);
    exp_q = {32'd5, 32'd7, 32'd13, 32'd15};
    check_outs("after_rst");

    // Random gaps on both sides over three frames, against the reference.
    obs_q = {};
    model_q = {};
    rand_out = 1'b1;
    for (int i = 0; i < 3 * W * H; i++) push($urandom, 1'b1);
    wait_outs(3 * OUTS);
    rand_out = 1'b0;
    out_ready = 1'b1;
    wait_outs(3 * OUTS);
    check("rand_model_cnt", model_q.size(), 32'(3 * OUTS));
    exp_q = model_q;
    check_outs("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
